// File: rtl/rgb_pwm_pkg.sv
// Shared encodings for the RGB PWM sequencer: lighting modes and colour-wheel geometry.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BIN     = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_WHEEL   = 2'b11
  } mode_e;

  localparam int         SEG_COUNT = 6;
  localparam logic [2:0] SEG_LAST  = 3'(SEG_COUNT - 1);

  // Breathing colour order cycles 1..7; a cleared index of 0 behaves as 1.
  function automatic logic [2:0] breathe_idx(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'd1 : idx;
  endfunction

  function automatic logic [2:0] breathe_next(input logic [2:0] idx);
    logic [2:0] cur;
    cur = breathe_idx(idx);
    return (cur == 3'd7) ? 3'd1 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_pwm_ch.sv
// One PWM channel: duty latched at period end, compare against the shared counter, registered pin.
// Pin follows the counter with 1 clk latency; an all-ones duty holds the LED fully lit.
module rgb_pwm_ch #(
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt,
  input  logic             pwm_end,
  input  logic [PWM_W-1:0] duty,
  output logic             pin
);

  localparam logic [PWM_W-1:0] MAX = '1;

  logic [PWM_W-1:0] act_duty;
  logic             on;

  assign on = (act_duty == MAX) ? 1'b1 : (cnt < act_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_duty <= '0;
      pin      <= ACTIVE_LOW;
    end else begin
      if (pwm_end) act_duty <= duty;
      pin <= on ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED pattern sequencer: switch-selected mode, tick-paced pattern state, brightness shift, 3 PWM pins.
// Switches reach the mode register 3 clk after a change; pins lag the PWM counter by 1 clk.
module rgb_pwm_sequencer
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int TICK_W     = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] SW,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  localparam logic [PWM_W-1:0] MAX = '1;
  localparam logic [PWM_W-1:0] ONE = PWM_W'(1);

  logic [3:0]        sw_m;
  logic [3:0]        sw_s;
  logic [TICK_W-1:0] pre;
  logic [PWM_W-1:0]  cnt;
  logic              tick;
  logic              pwm_end;

  mode_e             mode;
  mode_e             sw_mode;
  logic              mode_chg;
  logic [PWM_W-1:0]  lvl;
  logic              dir;
  logic [2:0]        seg;
  logic [2:0]        idx;
  logic [7:0]        sub;

  logic [PWM_W-1:0]  duty_r;
  logic [PWM_W-1:0]  duty_g;
  logic [PWM_W-1:0]  duty_b;
  logic [PWM_W-1:0]  duty_eff_r;
  logic [PWM_W-1:0]  duty_eff_g;
  logic [PWM_W-1:0]  duty_eff_b;

  assign tick     = &pre;
  assign pwm_end  = &cnt;
  assign sw_mode  = mode_e'(sw_s[1:0]);
  assign mode_chg = (sw_mode != mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= '0;
      sw_s <= '0;
      pre  <= '0;
      cnt  <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
      pre  <= pre + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

  // A mode change clears the pattern state and swallows any tick landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_OFF;
      lvl  <= '0;
      dir  <= 1'b0;
      seg  <= '0;
      idx  <= '0;
      sub  <= '0;
    end else if (mode_chg) begin
      mode <= sw_mode;
      lvl  <= '0;
      dir  <= 1'b0;
      seg  <= '0;
      idx  <= '0;
      sub  <= '0;
    end else if (tick) begin
      case (mode)
        MODE_BIN: begin
          sub <= sub + 8'd1;
          if (&sub) idx <= idx + 3'd1;
        end
        MODE_BREATHE: begin
          if (!dir) begin
            lvl <= lvl + ONE;
            idx <= breathe_idx(idx);
            if (lvl == MAX - ONE) dir <= 1'b1;
          end else begin
            lvl <= lvl - ONE;
            if (lvl == ONE) begin
              dir <= 1'b0;
              idx <= breathe_next(idx);
            end
          end
        end
        MODE_WHEEL: begin
          if (lvl == MAX) begin
            lvl <= '0;
            seg <= (seg == SEG_LAST) ? 3'd0 : seg + 3'd1;
          end else begin
            lvl <= lvl + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    case (mode)
      MODE_BIN: begin
        duty_r = idx[0] ? MAX : '0;
        duty_g = idx[1] ? MAX : '0;
        duty_b = idx[2] ? MAX : '0;
      end
      MODE_BREATHE: begin
        duty_r = idx[0] ? lvl : '0;
        duty_g = idx[1] ? lvl : '0;
        duty_b = idx[2] ? lvl : '0;
      end
      MODE_WHEEL: begin
        case (seg)
          3'd0: begin duty_r = MAX;       duty_g = lvl;       end
          3'd1: begin duty_r = MAX - lvl; duty_g = MAX;       end
          3'd2: begin duty_g = MAX;       duty_b = lvl;       end
          3'd3: begin duty_g = MAX - lvl; duty_b = MAX;       end
          3'd4: begin duty_r = lvl;       duty_b = MAX;       end
          default: begin duty_r = MAX;    duty_b = MAX - lvl; end
        endcase
      end
      default: ;
    endcase
  end

  assign duty_eff_r = duty_r >> sw_s[3:2];
  assign duty_eff_g = duty_g >> sw_s[3:2];
  assign duty_eff_b = duty_b >> sw_s[3:2];

  rgb_pwm_ch #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .pwm_end(pwm_end), .duty(duty_eff_r), .pin(LED_R)
  );

  rgb_pwm_ch #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .pwm_end(pwm_end), .duty(duty_eff_g), .pin(LED_G)
  );

  rgb_pwm_ch #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .pwm_end(pwm_end), .duty(duty_eff_b), .pin(LED_B)
  );

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer at PWM_W=4, TICK_W=2: cyc counts clk edges since reset release,
// so the PWM counter equals cyc mod 16 and ticks fire on edges where cyc mod 4 == 0.
module tb_rgb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0011;
  logic       led_r;
  logic       led_g;
  logic       led_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int br_exp[9] = '{2, 6, 10, 14, 12, 8, 4, 0, 0};
  int bg_exp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 4};

  always #5 clk = ~clk;

  rgb_pwm_sequencer #(.PWM_W(4), .TICK_W(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .SW(sw), .LED_R(led_r), .LED_G(led_g), .LED_B(led_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    if (cyc > n) check("schedule", cyc, n);
    while (cyc < n) step();
  endtask

  // Counts lit (low) samples over one PWM period; lit samples must form a prefix of the period.
  task automatic measure(input string tag, input int er, input int eg, input int eb);
    int nr, ng, nb;
    bit hr, hg, hb, ok;
    nr = 0; ng = 0; nb = 0;
    hr = 0; hg = 0; hb = 0; ok = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (!led_r) begin nr++; if (hr) ok = 0; end else hr = 1;
      if (!led_g) begin ng++; if (hg) ok = 0; end else hg = 1;
      if (!led_b) begin nb++; if (hb) ok = 0; end else hb = 1;
    end
    check({tag, "_r"}, nr, er);
    check({tag, "_g"}, ng, eg);
    check({tag, "_b"}, nb, eb);
    check({tag, "_shape"}, int'(ok), 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_leds", int'({led_r, led_g, led_b}), 7);
    end
    rst_n = 1'b1;
    cyc = 0;

    step();
    check("post_rst_leds", int'({led_r, led_g, led_b}), 7);
    step();
    check("mode_before_sync", int'(dut.mode), 0);
    step();
    check("mode_wheel_3clk", int'(dut.mode), 3);

    run_to(5);
    sw = 4'b0001;
    run_to(8);
    check("mode_bin", int'(dut.mode), 1);

    run_to(1024);
    measure("bin_idx0", 0, 0, 0);
    measure("bin_idx1", 16, 0, 0);
    run_to(2064);
    measure("bin_idx2", 0, 16, 0);

    run_to(7200);
    sw = 4'b1001;
    run_to(7216);
    measure("bin_idx7_dim", 3, 3, 3);

    run_to(7234);
    sw = 4'b0010;
    run_to(7248);
    for (int k = 0; k < 9; k++) measure("breathe", br_exp[k], bg_exp[k], 0);

    run_to(7393);
    sw = 4'b0000;
    run_to(7395);
    check("pre_clear_lvl", int'(dut.lvl), 9);
    check("pre_clear_idx", int'(dut.idx), 2);
    run_to(7396);
    check("clear_tick_lvl", int'(dut.lvl), 0);
    check("clear_tick_idx", int'(dut.idx), 0);
    check("clear_tick_dir", int'(dut.dir), 0);
    check("mode_off", int'(dut.mode), 0);
    run_to(7408);
    measure("off", 0, 0, 0);

    run_to(7429);
    sw = 4'b0011;
    run_to(7432);
    check("wheel_clear_lvl", int'(dut.lvl), 0);
    check("wheel_clear_seg", int'(dut.seg), 0);
    run_to(7436);
    check("wheel_first_tick", int'(dut.lvl), 1);

    run_to(7504);
    measure("wheel_s1_l1", 14, 16, 0);
    measure("wheel_s1_l5", 10, 16, 0);

    run_to(7815);
    check("wheel_seg5", int'(dut.seg), 5);
    check("wheel_seg5_lvl", int'(dut.lvl), 15);
    step();
    check("wheel_wrap_seg", int'(dut.seg), 0);
    check("wheel_wrap_lvl", int'(dut.lvl), 0);
    run_to(7824);
    measure("wheel_wrap", 16, 1, 0);

    step();
    check("pre_reset_r", int'(led_r), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_leds", int'({led_r, led_g, led_b}), 7);
    check("async_rst_mode", int'(dut.mode), 0);
    check("async_rst_lvl", int'(dut.lvl), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
